fp_single_divider: RTL and testbench

Sequential IEEE-754 single-precision divider computing `a / b`; it is the inverse-operation companion to the single-precision multiplier datapath. It uses restoring radix-2 mantissa division, one quotient bit per cycle. Results are truncated, matching the multiplier's accuracy class. Operands and results move over valid/ready handshakes, so the block drops between the operand memories and the capture logic.

---
 rtl/fp_single_pkg.sv | 23 ++
 rtl/fp_div_normalizer.sv | 47 ++++
 rtl/fp_single_divider.sv | 129 ++++++++++++
 tb/tb_fp_single_divider.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp_single_pkg.sv
// Shared single-precision definitions used by the divider and its normalizer.
// Field widths, the result layout and the divider state encoding.
package fp_single_pkg;

   localparam int         BIAS    = 127;
   localparam int         EXP_W   = 8;
   localparam int         MANT_W  = 23;
   localparam logic [7:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp_single_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_NORM,
      S_DONE
   } div_state_e;

endpackage

// File: rtl/fp_div_normalizer.sv
// Combinational normalization of the raw 25-bit quotient into a truncated
// single-precision result, including the zero/infinity override priority.
module fp_div_normalizer
   import fp_single_pkg::*;
(
   input  logic [24:0]       q_i,
   input  logic signed [9:0] e_i,
   input  logic              s_i,
   input  logic              za_i,
   input  logic              zb_i,
   output logic [31:0]       res_o
);

   logic signed [9:0] exp_fin;
   logic [MANT_W-1:0] mant;
   fp_single_t        res;

   always_comb begin
      res      = '0;
      res.sign = s_i;
      // Quotient lies in (0.5, 2): the leading bit picks the binade.
      if (q_i[24]) begin
         mant    = q_i[23:1];
         exp_fin = e_i;
      end else begin
         mant    = q_i[22:0];
         exp_fin = e_i - 10'sd1;
      end

      if (za_i) begin
         res.exp  = '0;
         res.mant = '0;
      end else if (zb_i || exp_fin >= 10'sd255) begin
         res.exp  = EXP_MAX;
         res.mant = '0;
      end else if (exp_fin <= 10'sd0) begin
         res.exp  = '0;
         res.mant = '0;
      end else begin
         res.exp  = exp_fin[EXP_W-1:0];
         res.mant = mant;
      end
   end

   assign res_o = res;

endmodule

// File: rtl/fp_single_divider.sv
// Sequential IEEE-754 single-precision divider, restoring radix-2, one quotient
// bit per cycle, truncated result, valid/ready on both sides.
module fp_single_divider
   import fp_single_pkg::*;
#(
   parameter int ITER = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam int CNT_W = $clog2(ITER);
   localparam int REM_W = MANT_W + 2;

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [REM_W-1:0]  div_q, div_d;
   logic [ITER-1:0]   q_q, q_d;
   logic signed [9:0] e_q, e_d;
   logic              s_q, s_d;
   logic              za_q, za_d;
   logic              zb_q, zb_d;
   logic [31:0]       result_q, result_d;

   logic              borrow;
   logic [REM_W-1:0]  diff;
   logic              ge;
   logic              last_iter;
   logic [31:0]       norm_res;

   assign {borrow, diff} = {1'b0, rem_q} - {1'b0, div_q};
   assign ge             = ~borrow;
   assign last_iter      = (cnt_q == CNT_W'(ITER - 1));

   fp_div_normalizer u_norm (
      .q_i   (q_q),
      .e_i   (e_q),
      .s_i   (s_q),
      .za_i  (za_q),
      .zb_i  (zb_q),
      .res_o (norm_res)
   );

   always_comb begin
      // NOTE: every target gets a hold value first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      div_d    = div_q;
      q_d      = q_q;
      e_d      = e_q;
      s_d      = s_q;
      za_d     = za_q;
      zb_d     = zb_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               s_d     = a[31] ^ b[31];
               e_d     = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(BIAS);
               rem_d   = {2'b01, a[22:0]};
               div_d   = {2'b01, b[22:0]};
               za_d    = (a[30:23] == '0);
               zb_d    = (b[30:23] == '0);
               q_d     = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Shifting left fills q MSB-first, equivalent to writing q[24-cnt].
            q_d   = {q_q[ITER-2:0], ge};
            rem_d = ge ? (diff << 1) : (rem_q << 1);
            cnt_d = cnt_q + 1'b1;
            if (last_iter) state_d = S_NORM;
         end
         S_NORM: begin
            result_d = norm_res;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset too, so an aborted division leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         q_q      <= '0;
         e_q      <= '0;
         s_q      <= 1'b0;
         za_q     <= 1'b0;
         zb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         q_q      <= q_d;
         e_q      <= e_d;
         s_q      <= s_d;
         za_q     <= za_d;
         zb_q     <= zb_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_fp_single_divider.sv
// Scoreboard bench for fp_single_divider: directed cases with known answers,
// an abort by reset, and random operands against an integer-arithmetic model.
module tb_fp_single_divider;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_q[$];

   fp_single_divider #(.ITER(25)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Quotient of the significands as floor(ma * 2^24 / mb), then IEEE packing.
   function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
      longint unsigned mx, my, qq;
      int              ex;
      logic            s;
      logic [22:0]     m;
      s = x[31] ^ y[31];
      if (x[30:23] == 8'd0) return {s, 31'b0};
      if (y[30:23] == 8'd0) return {s, 8'hFF, 23'b0};
      mx = 64'({1'b1, x[22:0]});
      my = 64'({1'b1, y[22:0]});
      qq = (mx << 24) / my;
      ex = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (qq >= (64'd1 << 24)) begin
         m = 23'((qq >> 1) & 64'h7FFFFF);
      end else begin
         m  = 23'(qq & 64'h7FFFFF);
         ex = ex - 1;
      end
      if (ex >= 255) return {s, 8'hFF, 23'b0};
      if (ex <= 0) return {s, 31'b0};
      return {s, 8'(ex), m};
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            check("result", result, exp_q.pop_front());
         end
      end
   end

   task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] expv, input int stall);
      int          cyc;
      bit          bad;
      logic [31:0] held;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("in_ready_before_op", 32'(in_ready), 32'd1);
      a         = op_a;
      b         = op_b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      exp_q.push_back(expv);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      cyc      = 0;
      bad      = 1'b0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'd26);
      check("in_ready_low_busy", 32'(bad), 32'd0);
      held = result;
      bad  = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (result !== held || in_ready || !out_valid) bad = 1'b1;
      end
      check("stall_hold", 32'(bad), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_after_handshake", 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 0);
      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0);
      do_op(32'hBF800000, 32'h3F000000, 32'hC0000000, 0);
      do_op(32'h00000000, 32'h40000000, 32'h00000000, 0);
      do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 0);
      do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 0);
      do_op(32'h00800000, 32'h40000000, 32'h00000000, 0);
      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 10);
      do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 0);

      // Abort a division with reset after 12 iterations.
      a        = 32'h40C00000;
      b        = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result", result, 32'h0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            ra[30:23] = 8'($urandom_range(100, 154));
            rb[30:23] = 8'($urandom_range(100, 154));
         end
         if ($urandom_range(0, 9) == 0) ra[30:23] = 8'd0;
         if ($urandom_range(0, 9) == 0) rb[30:23] = 8'd0;
         do_op(ra, rb, ref_div(ra, rb), $urandom_range(0, 3));
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
